// File: rtl/uart_sched_pkg.sv
// Shared tags, state encoding and frame word packing for the UART TX scheduler.
package uart_sched_pkg;

  localparam logic [7:0] HDR_TAG = 8'hA5;
  localparam logic [7:0] TRL_TAG = 8'h5A;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA,
    ST_TRAILER
  } state_t;

  function automatic logic [31:0] pack_header(input logic [3:0] id, input logic [15:0] seq);
    return {HDR_TAG, 4'h0, id, seq};
  endfunction

  // The trunc bit flags a packet closed by the stall timer rather than by last/MAX_WORDS.
  function automatic logic [31:0] pack_trailer(input logic trunc, input logic [3:0] id,
                                               input logic [15:0] cnt);
    return {TRL_TAG, 3'b000, trunc, id, cnt};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             valid
);

  logic [IDX_W:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (idx >= (IDX_W + 1)'(N)) idx = idx - (IDX_W + 1)'(N);
      if (!valid && req[idx[IDX_W-1:0]]) begin
        grant[idx[IDX_W-1:0]] = 1'b1;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares the UART TX FIFO write port between requesters, framing each granted
// packet with a header and trailer word under round-robin arbitration.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 256,
  parameter int TIMEOUT   = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                    i_tx_full,
  output logic                    o_wr_uart,
  output logic [DATA_W-1:0]       o_data,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic                    o_busy,
  output logic [15:0]             o_seq
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   gid_reg;
  logic [IDX_W-1:0]   ptr_reg;
  logic [15:0]        cnt_reg;
  logic               trunc_reg;
  logic [15:0]        seq_reg;
  logic [TMR_W-1:0]   stall_reg;

  logic [NUM_REQ-1:0] arb_grant;
  logic               arb_valid;
  logic [IDX_W-1:0]   arb_idx;
  logic [DATA_W-1:0]  req_word [NUM_REQ];
  logic [DATA_W-1:0]  cur_data;
  logic               cur_valid;
  logic               cur_last;
  logic               word_pending;
  logic [15:0]        cnt_inc;
  logic               data_done;
  logic               stall;
  logic               timeout_hit;

  rr_arbiter #(
    .N    (NUM_REQ),
    .IDX_W(IDX_W)
  ) u_arb (
    .req  (req_valid),
    .ptr  (ptr_reg),
    .grant(arb_grant),
    .valid(arb_valid)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) arb_idx = IDX_W'(i);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_word[gi]  = req_data[gi*DATA_W +: DATA_W];
      assign req_ready[gi] = (state_reg == ST_DATA) && (gid_reg == IDX_W'(gi)) && o_wr_uart;
      assign o_grant[gi]   = (state_reg != ST_IDLE) && (gid_reg == IDX_W'(gi));
    end
  endgenerate

  assign cur_data  = req_word[gid_reg];
  assign cur_valid = req_valid[gid_reg];
  assign cur_last  = req_last[gid_reg];
  assign o_wr_uart = word_pending & ~i_tx_full;
  assign o_busy    = (state_reg != ST_IDLE);
  assign o_seq     = seq_reg;

  assign cnt_inc   = cnt_reg + 16'd1;
  assign data_done = o_wr_uart & (cur_last | (cnt_inc == 16'(MAX_WORDS)));
  // Only cycles where the requester itself is silent count; FIFO-full stalls do not.
  assign stall       = (state_reg == ST_DATA) & ~cur_valid & ~i_tx_full;
  assign timeout_hit = stall & (stall_reg == TMR_W'(TIMEOUT - 2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:    if (i_enable && arb_valid) state_next = ST_HEADER;
      ST_HEADER:  if (o_wr_uart) state_next = ST_DATA;
      ST_DATA:    if (data_done || timeout_hit) state_next = ST_TRAILER;
      ST_TRAILER: if (o_wr_uart) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_data       = '0;
    word_pending = 1'b0;
    unique case (state_reg)
      ST_HEADER: begin
        o_data       = DATA_W'(pack_header(4'(gid_reg), seq_reg));
        word_pending = 1'b1;
      end
      ST_DATA: begin
        o_data       = cur_data;
        word_pending = cur_valid;
      end
      ST_TRAILER: begin
        o_data       = DATA_W'(pack_trailer(trunc_reg, 4'(gid_reg), cnt_reg));
        word_pending = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gid_reg   <= '0;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      trunc_reg <= 1'b0;
      seq_reg   <= '0;
      stall_reg <= '0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (i_enable && arb_valid) begin
            gid_reg   <= arb_idx;
            cnt_reg   <= '0;
            trunc_reg <= 1'b0;
            stall_reg <= '0;
          end
        end
        ST_HEADER: begin
          if (o_wr_uart) stall_reg <= '0;
        end
        ST_DATA: begin
          if (o_wr_uart) begin
            cnt_reg   <= cnt_inc;
            stall_reg <= '0;
          end else if (timeout_hit) begin
            trunc_reg <= 1'b1;
          end else if (stall) begin
            stall_reg <= stall_reg + 1'b1;
          end
        end
        ST_TRAILER: begin
          if (o_wr_uart) begin
            seq_reg <= seq_reg + 16'd1;
            ptr_reg <= (gid_reg == IDX_W'(NUM_REQ - 1)) ? '0 : gid_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: logs every FIFO write and compares
// against hand-computed frame sequences.
module tb_uart_tx_scheduler;

  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_enable;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_last;
  logic [NR*32-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          i_tx_full;
  logic          o_wr_uart;
  logic [31:0]   o_data;
  logic [NR-1:0] o_grant;
  logic          o_busy;
  logic [15:0]   o_seq;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [32:0] srcq [NR][$];
  logic [31:0] wr_log [$];
  int          wr_cyc [$];
  logic [3:0]  wr_gnt [$];
  logic [31:0] exp_q [$];
  logic [NR-1:0] rdy_s;

  uart_tx_scheduler #(
    .NUM_REQ  (NR),
    .DATA_W   (32),
    .MAX_WORDS(4),
    .TIMEOUT  (8)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .i_enable (i_enable),
    .req_valid(req_valid),
    .req_last (req_last),
    .req_data (req_data),
    .req_ready(req_ready),
    .i_tx_full(i_tx_full),
    .o_wr_uart(o_wr_uart),
    .o_data   (o_data),
    .o_grant  (o_grant),
    .o_busy   (o_busy),
    .o_seq    (o_seq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_wr_uart) begin
      wr_log.push_back(o_data);
      wr_cyc.push_back(cyc);
      wr_gnt.push_back(o_grant);
      $display("wr cyc=%0d data=%h grant=%b", cyc, o_data, o_grant);
    end
  end

  // Requester model: each source presents the head of its queue and pops on acceptance.
  initial begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    rdy_s     = '0;
    forever begin
      @(negedge clk);
      rdy_s = req_ready;
      @(posedge clk);
      #1;
      for (int k = 0; k < NR; k++) begin
        if (rdy_s[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
        if (srcq[k].size() > 0) begin
          req_valid[k]         = 1'b1;
          req_last[k]          = srcq[k][0][32];
          req_data[k*32 +: 32] = srcq[k][0][31:0];
        end else begin
          req_valid[k]         = 1'b0;
          req_last[k]          = 1'b0;
          req_data[k*32 +: 32] = '0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input int k, input logic [31:0] d, input logic l);
    srcq[k].push_back({l, d});
  endtask

  function automatic bit q_empty();
    bit e = 1'b1;
    for (int k = 0; k < NR; k++) if (srcq[k].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    wr_log.delete();
    wr_cyc.delete();
    wr_gnt.delete();
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      step();
      if (q_empty() && !o_busy) done = 1'b1;
    end
    check({tag, "_idle"}, 32'(done), 32'd1);
  endtask

  task automatic wait_log(input string tag, input int n);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      step();
      if (wr_log.size() >= n) done = 1'b1;
    end
    check({tag, "_reach"}, 32'(done), 32'd1);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_nwords"}, 32'(wr_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < wr_log.size()) check($sformatf("%s_w%0d", tag, i), wr_log[i], exp_q[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    i_enable  = 1'b1;
    i_tx_full = 1'b0;
    repeat (3) step();
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_wr", 32'(o_wr_uart), 32'd0);
    check("rst_data", o_data, 32'd0);
    check("rst_seq", 32'(o_seq), 32'd0);
    rst_n = 1'b1;
    step();

    // Single requester, 3-word packet
    clear_log();
    push(1, 32'h1111_0001, 1'b0);
    push(1, 32'h1111_0002, 1'b0);
    push(1, 32'h1111_0003, 1'b1);
    wait_idle("t1");
    exp_q = '{32'hA501_0000, 32'h1111_0001, 32'h1111_0002, 32'h1111_0003, 32'h5A01_0003};
    check_log("t1");
    if (wr_cyc.size() == 5) check("t1_span", 32'(wr_cyc[4] - wr_cyc[0]), 32'd4);
    check("t1_seq", 32'(o_seq), 32'd1);

    // Restart from reset so the pointer and sequence start over
    rst_n = 1'b0;
    #1;
    check("t2_rst_seq", 32'(o_seq), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    clear_log();
    push(0, 32'h0A0A_0001, 1'b1);
    push(0, 32'h0A0A_0002, 1'b1);
    push(2, 32'h0C0C_0001, 1'b1);
    push(2, 32'h0C0C_0002, 1'b1);
    wait_idle("t2");
    exp_q = '{32'hA500_0000, 32'h0A0A_0001, 32'h5A00_0001,
              32'hA502_0001, 32'h0C0C_0001, 32'h5A02_0001,
              32'hA500_0002, 32'h0A0A_0002, 32'h5A00_0001,
              32'hA502_0003, 32'h0C0C_0002, 32'h5A02_0001};
    check_log("t2");
    if (wr_gnt.size() == 12) begin
      check("t2_g0", 32'(wr_gnt[0]), 32'h1);
      check("t2_g1", 32'(wr_gnt[3]), 32'h4);
      check("t2_g2", 32'(wr_gnt[6]), 32'h1);
      check("t2_g3", 32'(wr_gnt[9]), 32'h4);
      check("t2_pkt_gap", 32'(wr_cyc[3] - wr_cyc[0]), 32'd4);
    end
    check("t2_seq", 32'(o_seq), 32'd4);

    // FIFO full for 5 cycles mid-payload
    clear_log();
    push(3, 32'hEEEE_0000, 1'b0);
    push(3, 32'hEEEE_0001, 1'b0);
    push(3, 32'hEEEE_0002, 1'b1);
    wait_log("t3", 2);
    i_tx_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      #1;
      check($sformatf("t3_wr_c%0d", i), 32'(o_wr_uart), 32'd0);
      check($sformatf("t3_rdy_c%0d", i), 32'(req_ready), 32'd0);
    end
    step();
    i_tx_full = 1'b0;
    wait_idle("t3");
    exp_q = '{32'hA503_0004, 32'hEEEE_0000, 32'hEEEE_0001, 32'hEEEE_0002, 32'h5A03_0003};
    check_log("t3");
    check("t3_seq", 32'(o_seq), 32'd5);

    // Grants held off while disabled, then stall timeout truncates the packet
    clear_log();
    i_enable = 1'b0;
    push(1, 32'hF00D_0000, 1'b0);
    push(1, 32'hF00D_0001, 1'b0);
    repeat (5) step();
    check("t4_disabled_busy", 32'(o_busy), 32'd0);
    i_enable = 1'b1;
    wait_idle("t4");
    exp_q = '{32'hA501_0005, 32'hF00D_0000, 32'hF00D_0001, 32'h5A11_0002};
    check_log("t4");
    if (wr_cyc.size() == 4) check("t4_timeout_gap", 32'(wr_cyc[3] - wr_cyc[2]), 32'd8);
    check("t4_seq", 32'(o_seq), 32'd6);

    // Packet length cap splits a 6-word source into two packets
    clear_log();
    for (int i = 0; i < 6; i++) push(2, 32'h6000_0000 + 32'(i), (i == 5));
    wait_idle("t5");
    exp_q = '{32'hA502_0006, 32'h6000_0000, 32'h6000_0001, 32'h6000_0002, 32'h6000_0003,
              32'h5A02_0004, 32'hA502_0007, 32'h6000_0004, 32'h6000_0005, 32'h5A02_0002};
    check_log("t5");
    check("t5_seq", 32'(o_seq), 32'd8);

    // Asynchronous reset mid-payload
    clear_log();
    push(0, 32'h7777_0000, 1'b0);
    push(0, 32'h7777_0001, 1'b0);
    wait_log("t6", 2);
    i_tx_full = 1'b1;
    #1;
    check("t6_pre_busy", 32'(o_busy), 32'd1);
    check("t6_pre_data", o_data, 32'h7777_0001);
    rst_n = 1'b0;
    for (int k = 0; k < NR; k++) srcq[k].delete();
    #1;
    check("t6_busy", 32'(o_busy), 32'd0);
    check("t6_grant", 32'(o_grant), 32'd0);
    check("t6_wr", 32'(o_wr_uart), 32'd0);
    check("t6_rdy", 32'(req_ready), 32'd0);
    check("t6_data", o_data, 32'd0);
    check("t6_seq", 32'(o_seq), 32'd0);
    i_tx_full = 1'b0;
    step();
    clear_log();
    rst_n = 1'b1;
    step();
    push(2, 32'h8888_0002, 1'b1);
    push(0, 32'h8888_0000, 1'b1);
    wait_idle("t6b");
    exp_q = '{32'hA500_0000, 32'h8888_0000, 32'h5A00_0001,
              32'hA502_0001, 32'h8888_0002, 32'h5A02_0001};
    check_log("t6b");
    if (wr_gnt.size() > 0) check("t6b_first_grant", 32'(wr_gnt[0]), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Packet-level scheduler that shares the 32-bit UART transmit FIFO write port between up to 16 on-chip requesters, e.g. the velocity-profile generator, position logger and status reporter. It grants one requester at a time with round-robin fairness and frames each packet with a header and a trailer word. It enforces FIFO backpressure and a stall timeout. It drives the UART block's write strobe and data directly and receives its full flag.

## Interface
- NUM_REQ, 4: number of requesters, 2..16
- DATA_W, 32: word width; must equal UART FIFO data width
- MAX_WORDS, 256: payload words per packet before forced close, 1..65535
- TIMEOUT, 1024: idle cycles mid-packet before truncation, ≥2
---
- clk, in, 1: system clock (12 MHz)
- reset, in, 1: asynchronous, active-low reset
- i_enable, in, 1: allow new grants; an in-flight packet always completes
- req_valid, in, NUM_REQ: per-requester word valid
- req_last, in, NUM_REQ: marks final payload word of the requester's packet
- req_data, in, NUM_REQ*DATA_W: requester k occupies bits [k*DATA_W +: DATA_W]
- req_ready, out, NUM_REQ: payload word of requester k accepted this cycle
- i_tx_full, in, 1: UART TX FIFO full
- o_wr_uart, out, 1: FIFO write strobe; one word per high cycle
- o_data, out, DATA_W: FIFO write data
- o_grant, out, NUM_REQ: one-hot current owner; zero when idle
- o_busy, out, 1: packet in flight (state ≠ IDLE)
- o_seq, out, 16: packets closed since reset

## Operation
- States: IDLE, HEADER, DATA, TRAILER.
- Accept condition: o_wr_uart = word_pending & ~i_tx_full, combinational. A word is written to the FIFO exactly in cycles where o_wr_uart=1.
- IDLE: if i_enable and any req_valid, register a grant to the first valid requester searching from (last_grant+1) mod NUM_REQ, clear cnt and trunc, then go to HEADER. The round-robin pointer resets so requester 0 wins first.
- HEADER: o_data = {8'hA5, 4'h0, id[3:0], seq[15:0]}, word_pending=1. On accept go to DATA.
- DATA: o_data = req_data[grant], word_pending = req_valid[grant], req_ready[grant] = o_wr_uart.
  - On each accept, cnt++.
  - Go to TRAILER when the accepted word has req_last[grant], or when the new cnt = MAX_WORDS.
- Stall timer: counts DATA cycles with req_valid[grant]=0 and resets on every accept. On reaching TIMEOUT, set trunc=1 and go to TRAILER. A word accepted in the same cycle has priority, and the timer restarts.
- Cycles with i_tx_full=1 never advance the stall timer.
- TRAILER: o_data = {8'h5A, 3'b0, trunc, id[3:0], cnt[15:0]}, word_pending=1. On accept: seq++ (wraps at 16 bits), last_grant = id, go to IDLE.
- req_ready of non-granted requesters is always 0. req_ready is never high while i_tx_full=1.
- Deasserting i_enable affects only the IDLE decision.
- Reset, asynchronous and at any time including mid-packet:
  - state IDLE; o_wr_uart=0, o_grant=0, o_busy=0, req_ready=0, o_data=0, o_seq=0, cnt=0, trunc=0, pointer at 0.
  - No trailer is emitted for an aborted packet.

## Timing
- Arbitration: 1 cycle. req_valid seen in IDLE at edge N gives the header on o_data in cycle N+1, written then if not full.
- Zero backpressure, 1-word packet: HEADER, DATA, TRAILER written in 3 consecutive cycles, then 1 IDLE cycle. Peak throughput is 1 word/cycle inside a packet.
- Payload is pass-through: o_data and req_ready depend combinationally on req_data, req_valid and i_tx_full in DATA. This is the only combinational input-to-output path.
- i_tx_full rising holds the current header, payload or trailer until full falls. No word is dropped or duplicated.
- o_grant and o_busy change only on clock edges. o_seq updates on the edge after trailer acceptance.

## Structure
- Package uart_sched_pkg holds:
  - HDR_TAG=8'hA5 and TRL_TAG=8'h5A;
  - the state encoding (2-bit enum);
  - the header/trailer pack functions.
- Sub-module rr_arbiter: combinational round-robin pick, taking the request vector and pointer and returning a one-hot grant plus a valid flag. It is reusable elsewhere.
- Datapath mux, counters and FSM live in uart_tx_scheduler.

## Test plan
- Single requester 1, 3-word packet (last on word 3), full=0 → writes A5_01_0000, d0, d1, d2, 5A_01_0003 on consecutive cycles; o_seq=1.
- Requesters 0 and 2 continuously valid, 1-word packets → grants alternate 0,2,0,2. Headers carry seq 0,1,2,3; no requester starved.
- i_tx_full held high 5 cycles mid-payload → o_wr_uart=0 and req_ready=0 for those cycles. The same word is written once after full falls, and the total word count is unchanged.
- Requester stops valid after 2 words, TIMEOUT=8 → trailer 5A_11_0002 (trunc=1, id=1) appears 8 cycles after the last accept; the scheduler returns to IDLE.
- MAX_WORDS=4 with a 6-word source → trailer after 4 words with trunc=0 and cnt=4. The remaining 2 words form the next packet with a new header.
- Reset pulled low during DATA → all outputs 0 asynchronously; after release, the first grant goes to requester 0 with seq 0.
